// File: rtl/mips_pkg.sv
// mips_pkg: shared size codes, skid-state encoding and a constant clog2 helper.
package mips_pkg;

    localparam int SIZE_BYTE = 0;
    localparam int SIZE_HALF = 1;
    localparam int SIZE_WORD = 2;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/lane_extend.sv
// lane_extend: picks a 2^k-lane field at a byte offset, sign/zero extends it, flags misalignment.
module lane_extend
    import mips_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int BYTE_WIDTH = 8,
    localparam int N_BYTES    = DATA_WIDTH / BYTE_WIDTH,
    localparam int OFF_WIDTH  = clog2(N_BYTES),
    localparam int SIZE_WIDTH = clog2(OFF_WIDTH + 1)
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [OFF_WIDTH-1:0]  i_offset,
    input  logic [SIZE_WIDTH-1:0] i_size,
    input  logic                  i_signed,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_misaligned
);

    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] ext;

    always_comb begin
        shifted = i_data >> (int'(i_offset) * BYTE_WIDTH);
        ext = '0;
        for (int k = 0; k <= OFF_WIDTH; k++)
            if (i_size == SIZE_WIDTH'(k))
                for (int b = 0; b < DATA_WIDTH; b++)
                    ext[b] = (b < (BYTE_WIDTH << k)) ? shifted[b] : (i_signed && shifted[(BYTE_WIDTH << k) - 1]);
        // sizes beyond a full word are illegal; their shift wraps the mask to all ones, which is harmless
        o_misaligned = (i_size > SIZE_WIDTH'(OFF_WIDTH)) ||
                       (|(i_offset & ((OFF_WIDTH'(1) << i_size) - OFF_WIDTH'(1))));
        o_data = o_misaligned ? '0 : ext;
    end

endmodule

// File: rtl/load_extend_pipe.sv
// load_extend_pipe: registered load extractor/extender with an output register plus skid slot.
module load_extend_pipe
    import mips_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int BYTE_WIDTH = 8,
    localparam int N_BYTES    = DATA_WIDTH / BYTE_WIDTH,
    localparam int OFF_WIDTH  = clog2(N_BYTES),
    localparam int SIZE_WIDTH = clog2(OFF_WIDTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [OFF_WIDTH-1:0]  i_offset,
    input  logic [SIZE_WIDTH-1:0] i_size,
    input  logic                  i_signed,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_misaligned
);

    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] ext_data, skid_data;
    logic                  ext_mis, skid_mis;
    logic                  accept, deliver, load_out, load_skid, skid_to_out;

    lane_extend #(.DATA_WIDTH(DATA_WIDTH), .BYTE_WIDTH(BYTE_WIDTH)) u_lane_extend (
        .i_data      (i_data),
        .i_offset    (i_offset),
        .i_size      (i_size),
        .i_signed    (i_signed),
        .o_data      (ext_data),
        .o_misaligned(ext_mis)
    );

    assign accept  = i_valid && o_ready;
    assign o_valid = state != EMPTY;
    assign deliver = o_valid && i_ready;

    always_comb begin
        state_n     = state;
        load_out    = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
        case (state)
            EMPTY: if (accept) begin
                state_n  = ONE;
                load_out = 1'b1;
            end
            ONE: begin
                load_out  = accept && deliver;
                load_skid = accept && !deliver;
                state_n   = load_skid ? TWO : (deliver && !accept) ? EMPTY : ONE;
            end
            TWO: if (deliver) begin
                state_n     = ONE;
                skid_to_out = 1'b1;
            end
            default: state_n = EMPTY;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= EMPTY;
            o_ready      <= 1'b0;
            o_data       <= '0;
            o_misaligned <= 1'b0;
            skid_data    <= '0;
            skid_mis     <= 1'b0;
        end else begin
            state   <= state_n;
            o_ready <= state_n != TWO;
            if (load_out) begin
                o_data       <= ext_data;
                o_misaligned <= ext_mis;
            end else if (skid_to_out) begin
                o_data       <= skid_data;
                o_misaligned <= skid_mis;
            end
            if (load_skid) begin
                skid_data <= ext_data;
                skid_mis  <= ext_mis;
            end
        end
    end

endmodule
